ve_writeback_queue: RTL and testbench
=====================================

// Module: ve_writeback_queue
// PURPOSE
//  Writeback stage directly downstream of the vector-scalar ALU (24 x 8-bit lanes, mul/div).
//  Buffers ALU results and their destination vector-register index in a small FIFO.
//  Drains the FIFO into the vector register file write port, which can stall via rf_ready.
//  Gives operand-forwarding lookups on queued, not-yet-written results.
// PARAMETERS
//  LANES   24   number of vector lanes
//  LANE_W  8    bits per lane; DATA_W = LANES*LANE_W (192 by default)
//  ADDR_W  5    vector register index width
//  DEPTH   4    FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1               clock, all state on rising edge
//  rst        in   1               synchronous reset, active-high
//  in_valid   in   1               ALU result present this cycle
//  in_ready   out  1               queue can accept
//  in_flag    in   1               ALU enable flag of the result; 0 = no writeback
//  in_rd      in   ADDR_W          destination vector register
//  in_result  in   DATA_W          ALU result, lane i = bits [i*LANE_W +: LANE_W]
//  wr_en      out  1               register-file write strobe
//  wr_addr    out  ADDR_W          register-file write index
//  wr_data    out  DATA_W          register-file write data
//  rf_ready   in   1               register-file port free this cycle
//  fwd_addr   in   ADDR_W          forwarding lookup index
//  fwd_hit    out  1               fwd_addr matches a queued entry
//  fwd_data   out  DATA_W          data of youngest matching entry, 0 when no hit
//  count      out  $clog2(DEPTH)+1 occupied entries
// BEHAVIOUR
//  - Reset: rd_ptr = wr_ptr = 0, count = 0, all entry-valid bits 0.
//  - Outputs during and right after reset: wr_en=0, fwd_hit=0, fwd_data=0, in_ready=0 while rst high.
//  - Reset mid-operation drops all queued entries. No write is issued in the reset cycle.
//  - in_ready = !rst && (count < DEPTH). It comes from registered count only; there is no full-queue bypass.
//  - Accept: in_valid && in_ready at the clock edge.
//    - Accepted with in_flag=1: {in_rd,in_result} stored at wr_ptr, wr_ptr++ mod DEPTH, count++.
//    - Accepted with in_flag=0: consumed and discarded; pointers and count unchanged.
//  - Drain: wr_en = (count != 0) && rf_ready; wr_addr/wr_data = head entry (combinational from storage).
//    - On wr_en, rd_ptr++ mod DEPTH and count--.
//  - Latency: earliest wr_en is the cycle after accept. An empty queue never bypasses.
//  - Simultaneous push and pop: count unchanged, both pointers advance.
//    - Allowed at any count < DEPTH. When full only a pop occurs, and in_ready rises next cycle.
//  - Pointer wrap: DEPTH-1 -> 0, natural binary wrap. count is authoritative for full/empty.
//  - Ordering: strict FIFO. Two entries to the same rd are written in accept order.
//  - Forwarding: compare fwd_addr against every valid entry, combinational.
//    - The youngest (closest to wr_ptr) match wins.
//    - An entry being popped this cycle still counts as a hit.
//    - Incoming in_result is not visible until stored.
//  - The block does no arithmetic on data; lanes pass through bit-exact.
//  - Assertions: count never exceeds DEPTH. wr_en never asserts when count is 0.
// TESTING
//  1) Reset then idle: count=0, wr_en=0, in_ready=1 the cycle after rst drops.
//     rst held high: in_ready=0.
//  2) Single push rd=3, result lanes=8'h05 each, rf_ready=1.
//     Next cycle: wr_en=1, wr_addr=3, wr_data={24{8'h05}}. Cycle after: count=0.
//  3) rf_ready=0, push 4 entries rd=1..4: count=4, in_ready=0, and a 5th push is not accepted.
//     Raise rf_ready: writes come out in order 1,2,3,4 on 4 consecutive cycles, and in_ready=1 after the first pop.
//  4) in_flag=0 push with rd=7: accepted (in_ready high), count stays 0, no wr_en ever issued for rd 7.
//  5) Forwarding with rf_ready=0: queue rd=2 data A then rd=2 data B.
//     fwd_addr=2 -> fwd_hit=1, fwd_data=B. fwd_addr=9 -> fwd_hit=0, fwd_data=0.
//  6) Full queue, simultaneous push+pop across wrap, then rst mid-drain.
//     Order is preserved across the wrap. After rst: count=0, wr_en=0, and no stale entry appears later.

Source files
------------

// File: rtl/ve_writeback_queue.sv
// Writeback queue between the vector-scalar ALU and the vector register file write port.
// Buffers flagged results in a small FIFO and answers forwarding lookups on queued entries.
module ve_writeback_queue #(
  parameter int LANES  = 24,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4,
  localparam int DATA_W = LANES * LANE_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_flag,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rf_ready,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  count
);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  vld;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  fwd_idx;
  logic              push;
  logic              pop;

  // Readiness comes only from the registered count, so a full queue never bypasses.
  assign in_ready = !rst && (count < CNT_W'(DEPTH));
  assign push     = in_valid && in_ready && in_flag;
  assign wr_en    = !rst && (count != '0) && rf_ready;
  assign pop      = wr_en;
  assign wr_addr  = rd_mem[rd_ptr];
  assign wr_data  = data_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Push and pop slots only coincide when empty or full, where one side is idle.
      if (pop)  vld[rd_ptr] <= 1'b0;
      if (push) vld[wr_ptr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= in_rd;
      data_mem[wr_ptr] <= in_result;
    end
  end

  // Scan oldest to youngest so the last match, the youngest entry, wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = rd_ptr + PTR_W'(i);
      if (!rst && vld[fwd_idx] && (rd_mem[fwd_idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[fwd_idx];
      end
    end
  end

  count_bounded: assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
  no_write_when_empty: assert property (@(posedge clk) disable iff (rst) !(wr_en && count == '0));

endmodule

// File: tb/tb_ve_writeback_queue.sv
// Bench for ve_writeback_queue: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a queue-based model.
module tb_ve_writeback_queue;
  localparam int LANES  = 24;
  localparam int LANE_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int DATA_W = LANES * LANE_W;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_flag = 1'b0;
  logic [ADDR_W-1:0] in_rd = '0;
  logic [DATA_W-1:0] in_result = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rf_ready = 1'b0;
  logic [ADDR_W-1:0] fwd_addr = '0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;

  int checks_total = 0;
  int checks_pass  = 0;

  logic [ADDR_W-1:0] m_rd   [$];
  logic [DATA_W-1:0] m_data [$];

  ve_writeback_queue #(.LANES(LANES), .LANE_W(LANE_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_flag(in_flag),
    .in_rd(in_rd), .in_result(in_result), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_ready(rf_ready), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks_total++;
    if (act === exp) checks_pass++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Inputs change just after the rising edge; returns at the falling edge for sampling.
  task automatic apply_stimulus(input logic r, input logic v, input logic f, input logic [ADDR_W-1:0] rd,
                                input logic [DATA_W-1:0] data, input logic rr, input logic [ADDR_W-1:0] fa);
    @(posedge clk);
    #1;
    rst = r; in_valid = v; in_flag = f; in_rd = rd; in_result = data; rf_ready = rr; fwd_addr = fa;
    @(negedge clk);
  endtask

  // Reference model: a plain FIFO of (rd, data) pairs.
  always @(posedge clk) begin : model_update
    bit do_pop;
    bit do_push;
    if (rst) begin
      m_rd.delete();
      m_data.delete();
    end else begin
      do_pop  = (m_rd.size() != 0) && rf_ready;
      do_push = in_valid && in_flag && (m_rd.size() < DEPTH);
      if (do_pop) begin
        void'(m_rd.pop_front());
        void'(m_data.pop_front());
      end
      if (do_push) begin
        m_rd.push_back(in_rd);
        m_data.push_back(in_result);
      end
    end
  end

  always @(negedge clk) begin : compare
    int n;
    logic exp_wr_en;
    logic exp_hit;
    logic [DATA_W-1:0] exp_fwd;
    n = m_rd.size();
    exp_wr_en = !rst && (n != 0) && rf_ready;
    exp_hit = 1'b0;
    exp_fwd = '0;
    if (!rst) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (m_rd[i] == fwd_addr) begin
          exp_hit = 1'b1;
          exp_fwd = m_data[i];
          break;
        end
      end
    end
    check_output("count", DATA_W'(count), DATA_W'(n));
    check_output("in_ready", DATA_W'(in_ready), DATA_W'(!rst && (n < DEPTH)));
    check_output("wr_en", DATA_W'(wr_en), DATA_W'(exp_wr_en));
    if (exp_wr_en) begin
      check_output("wr_addr", DATA_W'(wr_addr), DATA_W'(m_rd[0]));
      check_output("wr_data", wr_data, m_data[0]);
    end
    check_output("fwd_hit", DATA_W'(fwd_hit), DATA_W'(exp_hit));
    check_output("fwd_data", fwd_data, exp_fwd);
  end

  initial begin
    logic [DATA_W-1:0] d05;
    logic [DATA_W-1:0] da;
    logic [DATA_W-1:0] db;
    logic [ADDR_W-1:0] exp_pops [6];
    d05 = {24{8'h05}};

    // Reset then idle
    apply_stimulus(1, 0, 0, '0, '0, 0, '0);
    check_output("t1_ready_in_rst", DATA_W'(in_ready), DATA_W'(0));
    apply_stimulus(1, 0, 0, '0, '0, 1, '0);
    check_output("t1_ready_in_rst2", DATA_W'(in_ready), DATA_W'(0));
    check_output("t1_wr_en_in_rst", DATA_W'(wr_en), DATA_W'(0));
    apply_stimulus(0, 0, 0, '0, '0, 1, '0);
    check_output("t1_count", DATA_W'(count), DATA_W'(0));
    check_output("t1_wr_en", DATA_W'(wr_en), DATA_W'(0));
    check_output("t1_ready", DATA_W'(in_ready), DATA_W'(1));

    // Single push, written the next cycle
    apply_stimulus(0, 1, 1, ADDR_W'(3), d05, 1, '0);
    check_output("t2_no_bypass", DATA_W'(wr_en), DATA_W'(0));
    apply_stimulus(0, 0, 0, '0, '0, 1, '0);
    check_output("t2_wr_en", DATA_W'(wr_en), DATA_W'(1));
    check_output("t2_wr_addr", DATA_W'(wr_addr), DATA_W'(3));
    check_output("t2_wr_data", wr_data, d05);
    apply_stimulus(0, 0, 0, '0, '0, 1, '0);
    check_output("t2_count_after", DATA_W'(count), DATA_W'(0));

    // Fill with rf stalled, reject a fifth, then drain in order
    for (int i = 1; i <= 4; i++) apply_stimulus(0, 1, 1, ADDR_W'(i), rand_data(), 0, '0);
    apply_stimulus(0, 1, 1, ADDR_W'(5), rand_data(), 0, '0);
    check_output("t3_count_full", DATA_W'(count), DATA_W'(4));
    check_output("t3_ready_full", DATA_W'(in_ready), DATA_W'(0));
    for (int i = 1; i <= 4; i++) begin
      apply_stimulus(0, 0, 0, '0, '0, 1, '0);
      check_output("t3_wr_en", DATA_W'(wr_en), DATA_W'(1));
      check_output("t3_order", DATA_W'(wr_addr), DATA_W'(i));
      if (i == 2) check_output("t3_ready_after_pop", DATA_W'(in_ready), DATA_W'(1));
    end
    apply_stimulus(0, 0, 0, '0, '0, 1, '0);
    check_output("t3_fifth_dropped", DATA_W'(wr_en), DATA_W'(0));

    // Unflagged result is consumed without a write
    apply_stimulus(0, 1, 0, ADDR_W'(7), rand_data(), 1, '0);
    check_output("t4_ready", DATA_W'(in_ready), DATA_W'(1));
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, '0, '0, 1, '0);
      check_output("t4_count", DATA_W'(count), DATA_W'(0));
      check_output("t4_no_write", DATA_W'(wr_en), DATA_W'(0));
    end

    // Forwarding picks the youngest match, including an entry being popped
    da = rand_data();
    db = rand_data();
    apply_stimulus(0, 1, 1, ADDR_W'(2), da, 0, ADDR_W'(2));
    check_output("t5_not_visible_yet", DATA_W'(fwd_hit), DATA_W'(0));
    apply_stimulus(0, 1, 1, ADDR_W'(2), db, 0, ADDR_W'(2));
    check_output("t5_hit_a", fwd_data, da);
    apply_stimulus(0, 0, 0, '0, '0, 0, ADDR_W'(2));
    check_output("t5_model_size", DATA_W'(m_rd.size()), DATA_W'(2));
    check_output("t5_hit", DATA_W'(fwd_hit), DATA_W'(1));
    check_output("t5_data_b", fwd_data, db);
    apply_stimulus(0, 0, 0, '0, '0, 0, ADDR_W'(9));
    check_output("t5_miss", DATA_W'(fwd_hit), DATA_W'(0));
    check_output("t5_miss_data", fwd_data, '0);
    apply_stimulus(0, 0, 0, '0, '0, 1, ADDR_W'(2));
    check_output("t5_pop_a", wr_data, da);
    check_output("t5_hit_while_pop", fwd_data, db);
    apply_stimulus(0, 0, 0, '0, '0, 1, ADDR_W'(2));
    check_output("t5_last_pop_hit", DATA_W'(fwd_hit), DATA_W'(1));
    apply_stimulus(0, 0, 0, '0, '0, 1, ADDR_W'(2));
    check_output("t5_drained", DATA_W'(fwd_hit), DATA_W'(0));

    // Full queue, push+pop across the pointer wrap, then reset mid-drain
    for (int i = 0; i < 4; i++) apply_stimulus(0, 1, 1, ADDR_W'(10 + i), rand_data(), 0, '0);
    exp_pops = '{ADDR_W'(10), ADDR_W'(11), ADDR_W'(12), ADDR_W'(13), ADDR_W'(15), ADDR_W'(16)};
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(0, 1, 1, ADDR_W'(14 + k), rand_data(), 1, '0);
      check_output("t6_wrap_order", DATA_W'(wr_addr), DATA_W'(exp_pops[k]));
    end
    apply_stimulus(1, 1, 1, ADDR_W'(20), rand_data(), 1, ADDR_W'(17));
    check_output("t6_rst_wr_en", DATA_W'(wr_en), DATA_W'(0));
    check_output("t6_rst_hit", DATA_W'(fwd_hit), DATA_W'(0));
    check_output("t6_rst_ready", DATA_W'(in_ready), DATA_W'(0));
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 0, '0, '0, 1, ADDR_W'(17));
      check_output("t6_post_count", DATA_W'(count), DATA_W'(0));
      check_output("t6_no_stale", DATA_W'(wr_en), DATA_W'(0));
    end

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      apply_stimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                     ADDR_W'($urandom_range(0, 7)), rand_data(), ($urandom_range(0, 2) != 0),
                     ADDR_W'($urandom_range(0, 8)));
    end
    apply_stimulus(0, 0, 0, '0, '0, 1, '0);

    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end
endmodule
